// File: rtl/aqp_ebus_arbiter.sv
// Shares the external Z80 bus between two internal masters: obtains it via BUSREQ/BUSACK,
// grants it round-robin (non-preemptive) and muxes the owner onto ebus, all on phi falling edges.
module aqp_ebus_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ebus_phi,
    output logic        ebus_busreq_n,
    input  logic        ebus_busack_n,

    input  logic        m0_busreq,
    input  logic [15:0] m0_a,
    input  logic [7:0]  m0_wrdata,
    input  logic        m0_wrdata_en,
    input  logic [3:0]  m0_strb_n,
    output logic        m0_grant,

    input  logic        m1_busreq,
    input  logic [15:0] m1_a,
    input  logic [7:0]  m1_wrdata,
    input  logic        m1_wrdata_en,
    input  logic [3:0]  m1_strb_n,
    output logic        m1_grant,

    output logic [15:0] ebus_a,
    output logic [7:0]  ebus_wrdata,
    output logic        ebus_wrdata_en,
    output logic [3:0]  ebus_strb_n,
    output logic        arb_timeout
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STRB_W = 4;
    localparam logic [STRB_W-1:0] STRB_IDLE = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StReqCpu,
        StGrant,
        StHandover,
        StRelease
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busreq_n_q, busreq_n_d;
    logic               grant0_q, grant0_d;
    logic               grant1_q, grant1_d;
    logic               last_q, last_d;
    logic               timeout_q, timeout_d;
    logic               phi_q;
    logic               ack_meta_q, ack_sync_q;

    logic               phi_fall;
    logic               any_req;
    logic               win_m1;
    logic               holder_req;
    logic               other_req;
    logic [STRB_W-1:0]  holder_strb;

    // phi edge detect and BUSACK two-flop synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi_q      <= 1'b0;
            ack_meta_q <= 1'b1;
            ack_sync_q <= 1'b1;
        end else begin
            phi_q      <= ebus_phi;
            ack_meta_q <= ebus_busack_n;
            ack_sync_q <= ack_meta_q;
        end
    end

    assign phi_fall = phi_q & ~ebus_phi;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busreq_n_q <= 1'b1;
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
            last_q     <= 1'b1;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busreq_n_q <= busreq_n_d;
            grant0_q   <= grant0_d;
            grant1_q   <= grant1_d;
            last_q     <= last_d;
            timeout_q  <= timeout_d;
        end
    end

    // last_q==1 means m1 was granted most recently, so a tie goes to m0
    assign any_req     = m0_busreq | m1_busreq;
    assign win_m1      = m1_busreq & (~m0_busreq | ~last_q);
    assign holder_req  = grant1_q ? m1_busreq : m0_busreq;
    assign other_req   = grant1_q ? m0_busreq : m1_busreq;
    assign holder_strb = grant1_q ? m1_strb_n : m0_strb_n;

    // Next-state and registered-output logic; everything moves only at phi falling edges
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busreq_n_d = busreq_n_q;
        grant0_d   = grant0_q;
        grant1_d   = grant1_q;
        last_d     = last_q;
        timeout_d  = 1'b0;

        if (phi_fall) begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        busreq_n_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = StReqCpu;
                    end
                end
                StReqCpu: begin
                    if (!any_req) begin
                        busreq_n_d = 1'b1;
                        state_d    = StRelease;
                    end else if (!ack_sync_q) begin
                        grant0_d = ~win_m1;
                        grant1_d = win_m1;
                        last_d   = win_m1;
                        state_d  = StGrant;
                    end else if ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1) == (CNT_W+1)'(ACK_TIMEOUT)) begin
                        busreq_n_d = 1'b1;
                        timeout_d  = 1'b1;
                        cnt_d      = '0;
                        state_d    = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StGrant: begin
                    if (!holder_req && holder_strb == STRB_IDLE) begin
                        grant0_d = 1'b0;
                        grant1_d = 1'b0;
                        if (other_req) begin
                            state_d = StHandover;
                        end else begin
                            busreq_n_d = 1'b1;
                            state_d    = StRelease;
                        end
                    end
                end
                StHandover: begin
                    if (!any_req) begin
                        busreq_n_d = 1'b1;
                        state_d    = StRelease;
                    end else begin
                        grant0_d = ~win_m1;
                        grant1_d = win_m1;
                        last_d   = win_m1;
                        state_d  = StGrant;
                    end
                end
                StRelease: begin
                    if (ack_sync_q) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    busreq_n_d = 1'b1;
                    grant0_d   = 1'b0;
                    grant1_d   = 1'b0;
                    state_d    = StIdle;
                end
            endcase
        end
    end

    // Zero-latency bus mux from the registered grant
    always_comb begin
        ebus_a         = '0;
        ebus_wrdata    = '0;
        ebus_wrdata_en = 1'b0;
        ebus_strb_n    = STRB_IDLE;
        if (grant0_q) begin
            ebus_a         = m0_a;
            ebus_wrdata    = m0_wrdata;
            ebus_wrdata_en = m0_wrdata_en;
            ebus_strb_n    = m0_strb_n;
        end else if (grant1_q) begin
            ebus_a         = m1_a;
            ebus_wrdata    = m1_wrdata;
            ebus_wrdata_en = m1_wrdata_en;
            ebus_strb_n    = m1_strb_n;
        end
    end

    assign ebus_busreq_n = busreq_n_q;
    assign m0_grant      = grant0_q;
    assign m1_grant      = grant1_q;
    assign arb_timeout   = timeout_q;

endmodule

// File: tb/tb_aqp_ebus_arbiter.sv
// Bench for aqp_ebus_arbiter: directed scenarios plus a randomized run against a
// phi-cycle level model of bus ownership.
module tb_aqp_ebus_arbiter;

    localparam int unsigned ACK_TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ebus_phi;
    logic        ebus_busreq_n;
    logic        ebus_busack_n;
    logic        m0_busreq, m1_busreq;
    logic [15:0] m0_a, m1_a;
    logic [7:0]  m0_wrdata, m1_wrdata;
    logic        m0_wrdata_en, m1_wrdata_en;
    logic [3:0]  m0_strb_n, m1_strb_n;
    logic        m0_grant, m1_grant;
    logic [15:0] ebus_a;
    logic [7:0]  ebus_wrdata;
    logic        ebus_wrdata_en;
    logic [3:0]  ebus_strb_n;
    logic        arb_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the bus, whether the CPU bus is requested, pending gap/release
    bit m_cpu_req, m_gap, m_releasing, m_timeout;
    int m_owner, m_wait, m_last;

    aqp_ebus_arbiter #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .reset(reset),
        .ebus_phi(ebus_phi), .ebus_busreq_n(ebus_busreq_n), .ebus_busack_n(ebus_busack_n),
        .m0_busreq(m0_busreq), .m0_a(m0_a), .m0_wrdata(m0_wrdata),
        .m0_wrdata_en(m0_wrdata_en), .m0_strb_n(m0_strb_n), .m0_grant(m0_grant),
        .m1_busreq(m1_busreq), .m1_a(m1_a), .m1_wrdata(m1_wrdata),
        .m1_wrdata_en(m1_wrdata_en), .m1_strb_n(m1_strb_n), .m1_grant(m1_grant),
        .ebus_a(ebus_a), .ebus_wrdata(ebus_wrdata), .ebus_wrdata_en(ebus_wrdata_en),
        .ebus_strb_n(ebus_strb_n), .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_cpu_req = 0; m_gap = 0; m_releasing = 0; m_timeout = 0;
        m_owner = -1; m_wait = 0; m_last = 1;
    endtask

    task automatic model_release();
        m_cpu_req   = 0;
        m_releasing = 1;
    endtask

    // One phi falling edge worth of arbitration rules
    task automatic model_pf();
        bit r0, r1, hr, orq;
        logic [3:0] hs;
        int w;
        r0 = m0_busreq; r1 = m1_busreq;
        m_timeout = 0;
        if (r0 && r1) w = (m_last == 1) ? 0 : 1;
        else if (r0)  w = 0;
        else if (r1)  w = 1;
        else          w = -1;
        if (m_releasing) begin
            if (ebus_busack_n) m_releasing = 0;
        end else if (!m_cpu_req) begin
            if (r0 || r1) begin m_cpu_req = 1; m_wait = 0; end
        end else if (m_gap) begin
            m_gap = 0;
            if (w < 0) model_release();
            else begin m_owner = w; m_last = w; end
        end else if (m_owner >= 0) begin
            hr  = (m_owner == 0) ? r0 : r1;
            orq = (m_owner == 0) ? r1 : r0;
            hs  = (m_owner == 0) ? m0_strb_n : m1_strb_n;
            if (!hr && hs == 4'hF) begin
                m_owner = -1;
                if (orq) m_gap = 1;
                else model_release();
            end
        end else if (w < 0) begin
            model_release();
        end else if (!ebus_busack_n) begin
            m_owner = w; m_last = w;
        end else begin
            m_wait++;
            if (m_wait == ACK_TO) begin m_cpu_req = 0; m_timeout = 1; end
        end
    endtask

    task automatic idle_inputs();
        m0_busreq = 0; m1_busreq = 0;
        m0_a = '0; m1_a = '0; m0_wrdata = '0; m1_wrdata = '0;
        m0_wrdata_en = 0; m1_wrdata_en = 0;
        m0_strb_n = 4'hF; m1_strb_n = 4'hF;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        ebus_busack_n = 1'b1;
        ebus_phi = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One phi period; returns at the negedge just after the falling-edge clk cycle
    task automatic step();
        ebus_phi = 1'b1;
        repeat (3) @(negedge clk);
        ebus_phi = 1'b0;
        @(negedge clk);
        model_pf();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply_reset();
        n_tests++;
        if ({ebus_busreq_n, m0_grant, m1_grant, arb_timeout} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 1000", {ebus_busreq_n, m0_grant, m1_grant, arb_timeout});
        end
        n_tests++;
        if ({ebus_a, ebus_wrdata, ebus_wrdata_en, ebus_strb_n} !== {16'h0, 8'h0, 1'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL reset_bus: got a=%h d=%h en=%b s=%h want 0 0 0 F",
                     ebus_a, ebus_wrdata, ebus_wrdata_en, ebus_strb_n);
        end
    endtask

    task automatic test_single_grant();
        m0_busreq = 1; m0_a = 16'h3800;
        step();
        n_tests++;
        if ({ebus_busreq_n, m0_grant} !== 2'b00) begin
            n_fail++; $display("FAIL single_busreq: got %b want 00", {ebus_busreq_n, m0_grant});
        end
        step(); step();
        ebus_busack_n = 0;
        step();
        n_tests++;
        if ({m0_grant, m1_grant, ebus_a} !== {2'b10, 16'h3800}) begin
            n_fail++; $display("FAIL single_grant: got g=%b%b a=%h want 10 3800", m0_grant, m1_grant, ebus_a);
        end
        m0_busreq = 0;
        step();
        n_tests++;
        if ({ebus_busreq_n, m0_grant} !== 2'b10) begin
            n_fail++; $display("FAIL single_release: got %b want 10", {ebus_busreq_n, m0_grant});
        end
        ebus_busack_n = 1;
        step();
    endtask

    task automatic test_tie_handover();
        apply_reset();
        m0_busreq = 1; m1_busreq = 1; m0_a = 16'h1111; m1_a = 16'h2222;
        step();
        ebus_busack_n = 0;
        step();
        n_tests++;
        if ({m0_grant, m1_grant} !== 2'b10) begin
            n_fail++; $display("FAIL tie_first: got %b want 10", {m0_grant, m1_grant});
        end
        m0_busreq = 0;
        step();
        n_tests++;
        if ({ebus_busreq_n, m0_grant, m1_grant, ebus_a, ebus_strb_n} !== {3'b000, 16'h0, 4'hF}) begin
            n_fail++; $display("FAIL tie_gap: got rq=%b g=%b%b a=%h s=%h want 0 00 0000 F",
                               ebus_busreq_n, m0_grant, m1_grant, ebus_a, ebus_strb_n);
        end
        step();
        n_tests++;
        if ({ebus_busreq_n, m0_grant, m1_grant, ebus_a} !== {3'b001, 16'h2222}) begin
            n_fail++; $display("FAIL tie_second: got rq=%b g=%b%b a=%h want 0 01 2222",
                               ebus_busreq_n, m0_grant, m1_grant, ebus_a);
        end
    endtask

    task automatic test_strobe_hold();
        m0_busreq = 1;
        m1_strb_n = 4'b0101;
        m1_busreq = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({m0_grant, m1_grant, ebus_strb_n} !== {2'b01, 4'b0101}) begin
                n_fail++; $display("FAIL hold_strobe%0d: got g=%b%b s=%h want 01 5", i, m0_grant, m1_grant, ebus_strb_n);
            end
        end
        m1_strb_n = 4'hF;
        step();
        n_tests++;
        if ({ebus_busreq_n, m0_grant, m1_grant} !== 3'b000) begin
            n_fail++; $display("FAIL hold_gap: got %b want 000", {ebus_busreq_n, m0_grant, m1_grant});
        end
        step();
        n_tests++;
        if ({m0_grant, m1_grant, ebus_a} !== {2'b10, 16'h1111}) begin
            n_fail++; $display("FAIL hold_m0: got g=%b%b a=%h want 10 1111", m0_grant, m1_grant, ebus_a);
        end
        m0_busreq = 0;
        step();
        ebus_busack_n = 1;
        step();
    endtask

    task automatic test_timeout();
        m0_busreq = 1;
        ebus_busack_n = 1;
        step();
        for (int i = 1; i < int'(ACK_TO); i++) begin
            step();
            n_tests++;
            if ({ebus_busreq_n, arb_timeout} !== 2'b00) begin
                n_fail++; $display("FAIL timeout_wait%0d: got %b want 00", i, {ebus_busreq_n, arb_timeout});
            end
        end
        step();
        n_tests++;
        if ({ebus_busreq_n, arb_timeout, m0_grant} !== 3'b110) begin
            n_fail++; $display("FAIL timeout_fire: got %b want 110", {ebus_busreq_n, arb_timeout, m0_grant});
        end
        @(negedge clk);
        n_tests++;
        if (arb_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pulse: got %b want 0", arb_timeout);
        end
        m0_busreq = 0;
        step();
        n_tests++;
        if ({ebus_busreq_n, arb_timeout} !== 2'b10) begin
            n_fail++; $display("FAIL timeout_idle: got %b want 10", {ebus_busreq_n, arb_timeout});
        end
    endtask

    task automatic test_release_hold();
        m0_busreq = 1;
        step();
        ebus_busack_n = 0;
        step();
        m0_busreq = 0;
        step();
        m1_busreq = 1;
        step();
        n_tests++;
        if ({ebus_busreq_n, m0_grant, m1_grant} !== 3'b100) begin
            n_fail++; $display("FAIL release_held: got %b want 100", {ebus_busreq_n, m0_grant, m1_grant});
        end
        ebus_busack_n = 1;
        step();
        n_tests++;
        if ({ebus_busreq_n, m1_grant} !== 2'b10) begin
            n_fail++; $display("FAIL release_idle: got %b want 10", {ebus_busreq_n, m1_grant});
        end
        step();
        n_tests++;
        if ({ebus_busreq_n, m1_grant} !== 2'b00) begin
            n_fail++; $display("FAIL release_rereq: got %b want 00", {ebus_busreq_n, m1_grant});
        end
        ebus_busack_n = 0;
        step();
        n_tests++;
        if ({ebus_busreq_n, m0_grant, m1_grant} !== 3'b001) begin
            n_fail++; $display("FAIL release_m1: got %b want 001", {ebus_busreq_n, m0_grant, m1_grant});
        end
        m1_busreq = 0;
        step();
        ebus_busack_n = 1;
        step();
    endtask

    task automatic test_random();
        bit stubborn;
        bit target;
        logic [3:0]  exp_ctrl;
        logic [28:0] exp_bus;
        stubborn = 0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) m0_busreq = ~m0_busreq;
            if ($urandom_range(0, 3) == 0) m1_busreq = ~m1_busreq;
            m0_strb_n = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            m1_strb_n = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            m0_a = 16'($urandom); m1_a = 16'($urandom);
            m0_wrdata = 8'($urandom); m1_wrdata = 8'($urandom);
            m0_wrdata_en = 1'($urandom); m1_wrdata_en = 1'($urandom);
            step();
            exp_ctrl = {~m_cpu_req, m_owner == 0, m_owner == 1, m_timeout};
            if (m_owner == 0)      exp_bus = {m0_a, m0_wrdata, m0_wrdata_en, m0_strb_n};
            else if (m_owner == 1) exp_bus = {m1_a, m1_wrdata, m1_wrdata_en, m1_strb_n};
            else                   exp_bus = {16'h0, 8'h0, 1'b0, 4'hF};
            n_tests++;
            if ({ebus_busreq_n, m0_grant, m1_grant, arb_timeout} !== exp_ctrl) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
                                   {ebus_busreq_n, m0_grant, m1_grant, arb_timeout}, exp_ctrl);
            end
            n_tests++;
            if ({ebus_a, ebus_wrdata, ebus_wrdata_en, ebus_strb_n} !== exp_bus) begin
                n_fail++; $display("FAIL rand_bus[%0d]: got %h want %h", i,
                                   {ebus_a, ebus_wrdata, ebus_wrdata_en, ebus_strb_n}, exp_bus);
            end
            // Z80: answers a bus request after a random delay, occasionally never
            if (!m_cpu_req) stubborn = ($urandom_range(0, 5) == 0);
            target = !(m_cpu_req && !stubborn);
            if (ebus_busack_n != target && $urandom_range(0, 2) == 0) ebus_busack_n = target;
        end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        m0_busreq = 1;
        step();
        ebus_busack_n = 0;
        step();
        m0_a = 16'h3800; m0_wrdata = 8'hA5; m0_wrdata_en = 1; m0_strb_n = 4'b1001;
        #1;
        n_tests++;
        if ({ebus_strb_n, ebus_wrdata_en, ebus_wrdata} !== {4'b1001, 1'b1, 8'hA5}) begin
            n_fail++; $display("FAIL midwr_active: got s=%h en=%b d=%h want 9 1 a5", ebus_strb_n, ebus_wrdata_en, ebus_wrdata);
        end
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({ebus_strb_n, ebus_wrdata_en, ebus_busreq_n, m0_grant, ebus_a} !== {4'hF, 1'b0, 1'b1, 1'b0, 16'h0}) begin
            n_fail++; $display("FAIL midwr_reset: got s=%h en=%b rq=%b g=%b a=%h want F 0 1 0 0000",
                               ebus_strb_n, ebus_wrdata_en, ebus_busreq_n, m0_grant, ebus_a);
        end
        apply_reset();
    endtask

    initial begin
        reset = 1'b1;
        ebus_phi = 1'b0;
        ebus_busack_n = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_grant();
        test_tie_handover();
        test_strobe_hold();
        test_timeout();
        test_release_hold();
        test_random();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
